control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Moore-style control sequencer for the single-bus datapath. It fetches each instruction, decodes IR_Data[31:27],
//  and drives every datapath strobe (register enables, bus select, ALU opcode, RAM read/write) one T-step per clk.
//  Sits beside the datapath; its outputs connect 1:1 to the datapath control inputs, and it reads back IR_Data and con_output.
// PARAMETERS
//  MEM_WAIT  1  extra cycles ram_enable+read (or +write) are held before the access completes; legal range 0..7
// PORTS
//  clk            in   1   single system clock; all state updates on rising edge
//  clr            in   1   asynchronous, active-low reset
//  IR_Data        in   32  current instruction; [31:27] opcode
//  con_output     in   1   branch-condition flag from CON FF
//  stop           in   1   level; halt after the current instruction completes
//  PC_enable, PC_increment_enable, IR_enable, con_enable, ram_enable, Y_enable, Z_enable,
//  MAR_enable, MDR_enable, HI_enable, LO_enable, read, write        out 1 each  datapath strobes
//  Gra, Grb, Grc, r_enable, r_select, BAout                         out 1 each  select/encode controls
//  PC_select, HI_select, LO_select, Z_HI_select, Z_LO_select, MDR_select, InPort_select, c_select  out 1  bus source
//  alu_instruction out  5   ALU opcode; 0 when no ALU op is active
//  run             out  1   1 while sequencing; 0 in IDLE/HALT
//  illegal         out  1   one-cycle pulse on an unsupported opcode
// BEHAVIOUR
//  Reset: while clr=0, state=IDLE, wait counter=0, all outputs 0.
//   IDLE lasts exactly one cycle after release, then F0.
//  Decode: outputs are a pure function of state. At most one bus-source select is high in any cycle.
//  Fetch:
//   F0: PC_select, MAR_enable, PC_increment_enable.
//   FM: ram_enable, read for MEM_WAIT cycles (counter).
//   FL: ram_enable, read, MDR_enable (MDR captures MDataIN).
//   F2: MDR_select, IR_enable.
//   Next state is T3, or HALT if stop=1 was sampled at F2.
//  Execute (ALU ops set alu_instruction=opcode; address math uses 00011=add):
//   add..shl 00011-01011:
//     T3 Grb,r_select,Y_enable; T4 Grc,r_select,Z_enable,alu; T5 Z_LO_select,Gra,r_enable.
//   addi/andi/ori 01100-01110: as above, with c_select in T4.
//     alu = 00011 / 00101 / 00110 respectively.
//   neg/not 10001/10010: T3 Grb,r_select,Z_enable,alu; T4 Z_LO_select,Gra,r_enable.
//   mul/div 10000/01111:
//     T3 Gra,r_select,Y_enable; T4 Grb,r_select,Z_enable,alu; T5 Z_LO_select,LO_enable; T6 Z_HI_select,HI_enable.
//   ld 00000 / ldi 00001 / st 00010 share an address phase:
//     T3 Grb,BAout,Y_enable; T4 c_select,Z_enable,alu=00011.
//     ldi:  T5 Z_LO_select,Gra,r_enable.
//     ld:   T5 Z_LO_select,MAR_enable; then MEM_WAIT cycles ram_enable,read;
//           then ram_enable,read,MDR_enable; then MDR_select,Gra,r_enable.
//     st:   T5 Z_LO_select,MAR_enable; T6 Gra,r_select,MDR_enable (read=0);
//           then MEM_WAIT+1 cycles ram_enable,write.
//   br 10011:
//     T3 Gra,r_select,con_enable; T4 PC_select,Y_enable; T5 c_select,Z_enable,alu=00011;
//     T6 Z_LO_select, PC_enable=con_output (sampled in T6).
//   jr 10100: T3 Gra,r_select,PC_enable.
//   in 10110: T3 InPort_select,Gra,r_enable.
//   mfhi 11000 / mflo 11001: T3 HI_select / LO_select, Gra,r_enable.
//   nop 11010: T3 no strobes.
//   halt 11011: T3 then HALT.
//   jal 10101, out 10111, 11100-11111: illegal=1 for one cycle (T3), no strobes, next state F0.
//  Return to F0 after the last step of every instruction; no idle cycles between instructions.
//  HALT: absorbing state; run=0, no strobes; exit only via clr.
//  stop is honoured only at F2; an instruction already in T3+ always completes.
//  clr low mid-instruction: abort immediately. No partial write strobes after the asserting edge.
// TESTING
//  1 Reset: pulse clr low during st T6 -> all outputs 0 asynchronously. After release: 1 IDLE cycle, then F0 with
//    PC_select, MAR_enable, PC_increment_enable high.
//  2 MEM_WAIT=1, IR=0x191A0000 (add r2,r3,r4) -> 4 fetch + 3 exec cycles. T4: Grc, Z_enable, alu_instruction=00011.
//    T5: Gra, r_enable. Next cycle: F0.
//  3 MEM_WAIT=2, ld -> ram_enable&read high 3 consecutive cycles, MDR_enable only in the 3rd; MDR_select+r_enable next.
//  4 br with con_output=0 -> PC_enable never high; repeat with con_output=1 -> PC_enable high exactly 1 cycle,
//    together with Z_LO_select.
//  5 mul -> Z_enable once (T4); LO_enable at T5, HI_enable at T6, never in the same cycle.
//  6 opcode 11100 -> illegal 1 cycle, then F0. halt -> run=0, zero strobes for 20 cycles. stop=1 during add T4 ->
//    add completes, next F2 then HALT.
//  All: assertion that at most one bus-select output is high in every cycle.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: Moore control sequencer for the single-bus datapath.
// Fetches an instruction, decodes IR_Data[31:27] and steps one T-state per clk.
// Ports: clk/clr (async active-low), IR_Data + con_output read back from the
// datapath, stop (halt request at end of fetch), datapath strobes, register
// select/encode controls, bus-source selects, alu_instruction, run, illegal.
module control_unit #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR_Data,
  input  logic        con_output,
  input  logic        stop,
  output logic        PC_enable,
  output logic        PC_increment_enable,
  output logic        IR_enable,
  output logic        con_enable,
  output logic        ram_enable,
  output logic        Y_enable,
  output logic        Z_enable,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        HI_enable,
  output logic        LO_enable,
  output logic        read,
  output logic        write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        r_enable,
  output logic        r_select,
  output logic        BAout,
  output logic        PC_select,
  output logic        HI_select,
  output logic        LO_select,
  output logic        Z_HI_select,
  output logic        Z_LO_select,
  output logic        MDR_select,
  output logic        InPort_select,
  output logic        c_select,
  output logic [4:0]  alu_instruction,
  output logic        run,
  output logic        illegal
);

  localparam int unsigned ST_W  = 4;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned OP_W  = 5;

  localparam logic [ST_W-1:0] S_IDLE = 4'd0;
  localparam logic [ST_W-1:0] S_F0   = 4'd1;
  localparam logic [ST_W-1:0] S_FM   = 4'd2;
  localparam logic [ST_W-1:0] S_FL   = 4'd3;
  localparam logic [ST_W-1:0] S_F2   = 4'd4;
  localparam logic [ST_W-1:0] S_T3   = 4'd5;
  localparam logic [ST_W-1:0] S_T4   = 4'd6;
  localparam logic [ST_W-1:0] S_T5   = 4'd7;
  localparam logic [ST_W-1:0] S_T6   = 4'd8;
  localparam logic [ST_W-1:0] S_LDW  = 4'd9;
  localparam logic [ST_W-1:0] S_LDL  = 4'd10;
  localparam logic [ST_W-1:0] S_LDR  = 4'd11;
  localparam logic [ST_W-1:0] S_STW  = 4'd12;
  localparam logic [ST_W-1:0] S_HALT = 4'd13;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OP_W-1:0] OP_BR   = 5'b10011;
  localparam logic [OP_W-1:0] OP_JR   = 5'b10100;
  localparam logic [OP_W-1:0] OP_IN   = 5'b10110;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b11000;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b11001;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  localparam logic [OP_W-1:0] ALU_ADD = 5'b00011;
  localparam logic [OP_W-1:0] ALU_AND = 5'b00101;
  localparam logic [OP_W-1:0] ALU_OR  = 5'b00110;

  // Wait-state preload: ld/fetch hold MEM_WAIT cycles, st holds MEM_WAIT+1.
  localparam bit              HAS_WAIT  = (MEM_WAIT != 0);
  localparam logic [CNT_W-1:0] RD_PRELD = HAS_WAIT ? CNT_W'(MEM_WAIT - 1) : '0;
  localparam logic [CNT_W-1:0] WR_PRELD = CNT_W'(MEM_WAIT);

  logic [ST_W-1:0]  state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [OP_W-1:0]  opcode;
  logic             unused_ir;

  assign opcode    = IR_Data[31:27];
  assign unused_ir = ^IR_Data[26:0];

  // Opcode classes
  logic is_mem, is_alu3, is_imm, is_unary, is_muldiv, is_br, is_single, is_halt, is_multi;
  assign is_mem    = (opcode == OP_LD) || (opcode == OP_LDI) || (opcode == OP_ST);
  assign is_alu3   = (opcode >= OP_ADD) && (opcode <= OP_SHL);
  assign is_imm    = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
  assign is_unary  = (opcode == OP_NEG) || (opcode == OP_NOT);
  assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign is_br     = (opcode == OP_BR);
  assign is_single = (opcode == OP_JR) || (opcode == OP_IN) || (opcode == OP_MFHI) ||
                     (opcode == OP_MFLO) || (opcode == OP_NOP);
  assign is_halt   = (opcode == OP_HALT);
  assign is_multi  = is_mem || is_alu3 || is_imm || is_unary || is_muldiv || is_br;

  // State and wait counter
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state sequencing
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: state_nxt = S_F0;
      S_F0: begin
        if (HAS_WAIT) begin
          state_nxt = S_FM;
          cnt_nxt   = RD_PRELD;
        end else begin
          state_nxt = S_FL;
        end
      end
      S_FM: begin
        if (cnt == '0) state_nxt = S_FL;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      S_FL: state_nxt = S_F2;
      S_F2: state_nxt = stop ? S_HALT : S_T3;
      S_T3: begin
        if (is_multi)     state_nxt = S_T4;
        else if (is_halt) state_nxt = S_HALT;
        else              state_nxt = S_F0;
      end
      S_T4: state_nxt = is_unary ? S_F0 : S_T5;
      S_T5: begin
        if (opcode == OP_LD) begin
          if (HAS_WAIT) begin
            state_nxt = S_LDW;
            cnt_nxt   = RD_PRELD;
          end else begin
            state_nxt = S_LDL;
          end
        end else if ((opcode == OP_ST) || is_muldiv || is_br) begin
          state_nxt = S_T6;
        end else begin
          state_nxt = S_F0;
        end
      end
      S_T6: begin
        if (opcode == OP_ST) begin
          state_nxt = S_STW;
          cnt_nxt   = WR_PRELD;
        end else begin
          state_nxt = S_F0;
        end
      end
      S_LDW: begin
        if (cnt == '0) state_nxt = S_LDL;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      S_LDL: state_nxt = S_LDR;
      S_LDR: state_nxt = S_F0;
      S_STW: begin
        if (cnt == '0) state_nxt = S_F0;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobe decode from the state register and the (registered) IR opcode
  always_comb begin
    PC_enable = 1'b0; PC_increment_enable = 1'b0; IR_enable = 1'b0; con_enable = 1'b0;
    ram_enable = 1'b0; Y_enable = 1'b0; Z_enable = 1'b0; MAR_enable = 1'b0;
    MDR_enable = 1'b0; HI_enable = 1'b0; LO_enable = 1'b0; read = 1'b0; write = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; r_enable = 1'b0; r_select = 1'b0; BAout = 1'b0;
    PC_select = 1'b0; HI_select = 1'b0; LO_select = 1'b0; Z_HI_select = 1'b0;
    Z_LO_select = 1'b0; MDR_select = 1'b0; InPort_select = 1'b0; c_select = 1'b0;
    alu_instruction = '0;
    illegal = 1'b0;
    run = (state != S_IDLE) && (state != S_HALT);
    case (state)
      S_F0: begin PC_select = 1'b1; MAR_enable = 1'b1; PC_increment_enable = 1'b1; end
      S_FM, S_LDW: begin ram_enable = 1'b1; read = 1'b1; end
      S_FL, S_LDL: begin ram_enable = 1'b1; read = 1'b1; MDR_enable = 1'b1; end
      S_F2: begin MDR_select = 1'b1; IR_enable = 1'b1; end
      S_T3: begin
        if (is_mem) begin
          Grb = 1'b1; BAout = 1'b1; Y_enable = 1'b1;
        end else if (is_alu3 || is_imm) begin
          Grb = 1'b1; r_select = 1'b1; Y_enable = 1'b1;
        end else if (is_unary) begin
          Grb = 1'b1; r_select = 1'b1; Z_enable = 1'b1; alu_instruction = opcode;
        end else if (is_muldiv) begin
          Gra = 1'b1; r_select = 1'b1; Y_enable = 1'b1;
        end else if (is_br) begin
          Gra = 1'b1; r_select = 1'b1; con_enable = 1'b1;
        end else if (opcode == OP_JR) begin
          Gra = 1'b1; r_select = 1'b1; PC_enable = 1'b1;
        end else if (opcode == OP_IN) begin
          InPort_select = 1'b1; Gra = 1'b1; r_enable = 1'b1;
        end else if (opcode == OP_MFHI) begin
          HI_select = 1'b1; Gra = 1'b1; r_enable = 1'b1;
        end else if (opcode == OP_MFLO) begin
          LO_select = 1'b1; Gra = 1'b1; r_enable = 1'b1;
        end else if (!is_single && !is_halt) begin
          illegal = 1'b1;
        end
      end
      S_T4: begin
        if (is_mem) begin
          c_select = 1'b1; Z_enable = 1'b1; alu_instruction = ALU_ADD;
        end else if (is_alu3) begin
          Grc = 1'b1; r_select = 1'b1; Z_enable = 1'b1; alu_instruction = opcode;
        end else if (is_imm) begin
          // The immediate replaces the rc operand on the bus
          c_select = 1'b1; Z_enable = 1'b1;
          alu_instruction = (opcode == OP_ANDI) ? ALU_AND :
                            (opcode == OP_ORI)  ? ALU_OR  : ALU_ADD;
        end else if (is_unary) begin
          Z_LO_select = 1'b1; Gra = 1'b1; r_enable = 1'b1;
        end else if (is_muldiv) begin
          Grb = 1'b1; r_select = 1'b1; Z_enable = 1'b1; alu_instruction = opcode;
        end else if (is_br) begin
          PC_select = 1'b1; Y_enable = 1'b1;
        end
      end
      S_T5: begin
        if ((opcode == OP_LD) || (opcode == OP_ST)) begin
          Z_LO_select = 1'b1; MAR_enable = 1'b1;
        end else if ((opcode == OP_LDI) || is_alu3 || is_imm) begin
          Z_LO_select = 1'b1; Gra = 1'b1; r_enable = 1'b1;
        end else if (is_muldiv) begin
          Z_LO_select = 1'b1; LO_enable = 1'b1;
        end else if (is_br) begin
          c_select = 1'b1; Z_enable = 1'b1; alu_instruction = ALU_ADD;
        end
      end
      S_T6: begin
        if (opcode == OP_ST) begin
          Gra = 1'b1; r_select = 1'b1; MDR_enable = 1'b1;
        end else if (is_muldiv) begin
          Z_HI_select = 1'b1; HI_enable = 1'b1;
        end else if (is_br) begin
          Z_LO_select = 1'b1; PC_enable = con_output;
        end
      end
      S_LDR: begin MDR_select = 1'b1; Gra = 1'b1; r_enable = 1'b1; end
      S_STW: begin ram_enable = 1'b1; write = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench for control_unit. Two instances
// (MEM_WAIT=1 and MEM_WAIT=2) share inputs; each scenario checks one of them
// cycle by cycle against an expected strobe sequence built from the instruction
// step tables.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] ir = '0;
  logic        con = 1'b0;
  logic        stop = 1'b0;
  wire  [33:0] o1, o2;

  always #5 clk = ~clk;

  control_unit #(.MEM_WAIT(1)) u_dut1 (
    .clk(clk), .clr(clr), .IR_Data(ir), .con_output(con), .stop(stop),
    .PC_enable(o1[0]), .PC_increment_enable(o1[1]), .IR_enable(o1[2]), .con_enable(o1[3]),
    .ram_enable(o1[4]), .Y_enable(o1[5]), .Z_enable(o1[6]), .MAR_enable(o1[7]),
    .MDR_enable(o1[8]), .HI_enable(o1[9]), .LO_enable(o1[10]), .read(o1[11]), .write(o1[12]),
    .Gra(o1[13]), .Grb(o1[14]), .Grc(o1[15]), .r_enable(o1[16]), .r_select(o1[17]),
    .BAout(o1[18]), .PC_select(o1[19]), .HI_select(o1[20]), .LO_select(o1[21]),
    .Z_HI_select(o1[22]), .Z_LO_select(o1[23]), .MDR_select(o1[24]), .c_select(o1[25]),
    .InPort_select(o1[26]), .run(o1[27]), .illegal(o1[28]), .alu_instruction(o1[33:29])
  );

  control_unit #(.MEM_WAIT(2)) u_dut2 (
    .clk(clk), .clr(clr), .IR_Data(ir), .con_output(con), .stop(stop),
    .PC_enable(o2[0]), .PC_increment_enable(o2[1]), .IR_enable(o2[2]), .con_enable(o2[3]),
    .ram_enable(o2[4]), .Y_enable(o2[5]), .Z_enable(o2[6]), .MAR_enable(o2[7]),
    .MDR_enable(o2[8]), .HI_enable(o2[9]), .LO_enable(o2[10]), .read(o2[11]), .write(o2[12]),
    .Gra(o2[13]), .Grb(o2[14]), .Grc(o2[15]), .r_enable(o2[16]), .r_select(o2[17]),
    .BAout(o2[18]), .PC_select(o2[19]), .HI_select(o2[20]), .LO_select(o2[21]),
    .Z_HI_select(o2[22]), .Z_LO_select(o2[23]), .MDR_select(o2[24]), .c_select(o2[25]),
    .InPort_select(o2[26]), .run(o2[27]), .illegal(o2[28]), .alu_instruction(o2[33:29])
  );

  localparam logic [33:0] PCE  = 34'd1 << 0;
  localparam logic [33:0] PCI  = 34'd1 << 1;
  localparam logic [33:0] IRE  = 34'd1 << 2;
  localparam logic [33:0] CONE = 34'd1 << 3;
  localparam logic [33:0] RAM  = 34'd1 << 4;
  localparam logic [33:0] YE   = 34'd1 << 5;
  localparam logic [33:0] ZE   = 34'd1 << 6;
  localparam logic [33:0] MARE = 34'd1 << 7;
  localparam logic [33:0] MDRE = 34'd1 << 8;
  localparam logic [33:0] HIE  = 34'd1 << 9;
  localparam logic [33:0] LOE  = 34'd1 << 10;
  localparam logic [33:0] RD   = 34'd1 << 11;
  localparam logic [33:0] WR   = 34'd1 << 12;
  localparam logic [33:0] GRA  = 34'd1 << 13;
  localparam logic [33:0] GRB  = 34'd1 << 14;
  localparam logic [33:0] GRC  = 34'd1 << 15;
  localparam logic [33:0] RE   = 34'd1 << 16;
  localparam logic [33:0] RS   = 34'd1 << 17;
  localparam logic [33:0] BA   = 34'd1 << 18;
  localparam logic [33:0] PCS  = 34'd1 << 19;
  localparam logic [33:0] HIS  = 34'd1 << 20;
  localparam logic [33:0] LOS  = 34'd1 << 21;
  localparam logic [33:0] ZHS  = 34'd1 << 22;
  localparam logic [33:0] ZLS  = 34'd1 << 23;
  localparam logic [33:0] MDS  = 34'd1 << 24;
  localparam logic [33:0] CS   = 34'd1 << 25;
  localparam logic [33:0] INS  = 34'd1 << 26;
  localparam logic [33:0] RUN  = 34'd1 << 27;
  localparam logic [33:0] ILL  = 34'd1 << 28;

  logic [33:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [33:0] alu(input logic [4:0] op);
    return {op, 29'd0};
  endfunction

  // Sequencing step: run is high in every non-IDLE, non-HALT cycle
  task automatic push(input logic [33:0] v);
    exp_q.push_back(v | RUN);
  endtask

  task automatic push_z();
    exp_q.push_back('0);
  endtask

  task automatic push_fetch(input int mw);
    push(PCS | MARE | PCI);
    for (int k = 0; k < mw; k++) push(RAM | RD);
    push(RAM | RD | MDRE);
    push(MDS | IRE);
  endtask

  // Hold reset, load the instruction, release on a falling edge (IDLE visible now)
  task automatic start(input logic [4:0] op, input logic con_v);
    clr = 1'b0;
    stop = 1'b0;
    con = con_v;
    ir = {op, 4'd2, 4'd3, 4'd4, 15'd0};
    exp_q.delete();
    repeat (2) @(negedge clk);
    clr = 1'b1;
    push_z();
  endtask

  // Pop one expectation per cycle; returns still inside the last checked cycle
  task automatic run_check(input int inst, input string name, input int stop_cycle);
    logic [33:0] e, o;
    int i;
    i = 0;
    while (exp_q.size() > 0) begin
      if (i > 0) @(negedge clk);
      e = exp_q.pop_front();
      o = (inst == 1) ? o1 : o2;
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, i, o, e);
      end
      if (i == stop_cycle) stop = 1'b1;
      i++;
    end
  endtask

  // At most one bus source driving in any cycle, on both instances
  always @(negedge clk) begin
    if (clr) begin
      n_cmp++;
      if ($countones(o1[26:17]) > 1 || $countones(o2[26:17]) > 1) begin
        n_bad++;
        $display("FAIL bus_onehot: got %h / %h expected at most one select", o1[26:17], o2[26:17]);
      end
    end
  end

  task automatic test_reset();
    start(5'b00010, 1'b0);
    push_fetch(1);
    push(GRB | BA | YE);
    push(CS | ZE | alu(5'b00011));
    push(ZLS | MARE);
    push(GRA | RS | MDRE);
    run_check(1, "st_to_t6", -1);
    #2 clr = 1'b0;
    #1;
    n_cmp++;
    if (o1 !== 34'd0) begin
      n_bad++;
      $display("FAIL reset_async: got %h expected %h", o1, 34'd0);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (o1 !== 34'd0) begin
      n_bad++;
      $display("FAIL reset_hold: got %h expected %h", o1, 34'd0);
    end
    @(negedge clk);
    clr = 1'b1;
    push_z();
    push(PCS | MARE | PCI);
    run_check(1, "reset_release", -1);
  endtask

  task automatic test_add();
    start(5'b00011, 1'b0);
    push_fetch(1);
    push(GRB | RS | YE);
    push(GRC | RS | ZE | alu(5'b00011));
    push(ZLS | GRA | RE);
    push(PCS | MARE | PCI);
    run_check(1, "add", -1);
  endtask

  task automatic test_ld_wait2();
    start(5'b00000, 1'b0);
    push_fetch(2);
    push(GRB | BA | YE);
    push(CS | ZE | alu(5'b00011));
    push(ZLS | MARE);
    push(RAM | RD);
    push(RAM | RD);
    push(RAM | RD | MDRE);
    push(MDS | GRA | RE);
    push(PCS | MARE | PCI);
    run_check(2, "ld_wait2", -1);
  endtask

  task automatic test_br(input logic c);
    start(5'b10011, c);
    push_fetch(1);
    push(GRA | RS | CONE);
    push(PCS | YE);
    push(CS | ZE | alu(5'b00011));
    push(ZLS | (c ? PCE : 34'd0));
    push(PCS | MARE | PCI);
    run_check(1, c ? "br_taken" : "br_not_taken", -1);
  endtask

  task automatic test_mul();
    start(5'b10000, 1'b0);
    push_fetch(1);
    push(GRA | RS | YE);
    push(GRB | RS | ZE | alu(5'b10000));
    push(ZLS | LOE);
    push(ZHS | HIE);
    push(PCS | MARE | PCI);
    run_check(1, "mul", -1);
  endtask

  task automatic test_andi_neg();
    start(5'b01101, 1'b0);
    push_fetch(1);
    push(GRB | RS | YE);
    push(CS | ZE | alu(5'b00101));
    push(ZLS | GRA | RE);
    push(PCS | MARE | PCI);
    run_check(1, "andi", -1);
    start(5'b10001, 1'b0);
    push_fetch(1);
    push(GRB | RS | ZE | alu(5'b10001));
    push(ZLS | GRA | RE);
    push(PCS | MARE | PCI);
    run_check(1, "neg", -1);
  endtask

  task automatic test_illegal_halt();
    start(5'b11100, 1'b0);
    push_fetch(1);
    push(ILL);
    push(PCS | MARE | PCI);
    run_check(1, "illegal", -1);
    start(5'b11011, 1'b0);
    push_fetch(1);
    push(34'd0);
    for (int k = 0; k < 20; k++) push_z();
    run_check(1, "halt", -1);
  endtask

  // stop raised in add T4 (cycle 6): add finishes, next fetch runs, then HALT
  task automatic test_stop();
    start(5'b00011, 1'b0);
    push_fetch(1);
    push(GRB | RS | YE);
    push(GRC | RS | ZE | alu(5'b00011));
    push(ZLS | GRA | RE);
    push_fetch(1);
    for (int k = 0; k < 3; k++) push_z();
    run_check(1, "stop_in_t4", 6);
    stop = 1'b0;
  endtask

  task automatic test_back_to_back();
    start(5'b11001, 1'b0);
    for (int k = 0; k < 2; k++) begin
      push_fetch(2);
      push(LOS | GRA | RE);
    end
    push(PCS | MARE | PCI);
    run_check(2, "mflo_b2b", -1);
    start(5'b10100, 1'b0);
    for (int k = 0; k < 2; k++) begin
      push_fetch(1);
      push(GRA | RS | PCE);
    end
    push(PCS | MARE | PCI);
    run_check(1, "jr_b2b", -1);
  endtask

  initial begin
    test_reset();
    test_add();
    test_ld_wait2();
    test_br(1'b0);
    test_br(1'b1);
    test_mul();
    test_andi_neg();
    test_illegal_halt();
    test_stop();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
